// File: rtl/branch_predict_unit.sv
// Branch predict unit: a direct-mapped, tagged table of branch targets with saturating
// direction counters. It also keeps branch/mispredict statistics. The optional return-address
// stack is enabled by defining BPU_RAS_EN. When that macro is undefined, the RAS ports remain,
// but ras_top reads 0 and ras_empty reads 1.
module branch_predict_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
    logic [31:0]         stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    logic [IDX-1:0]   if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit;
    logic             unused_pc_lsbs;

    assign if_idx         = if_pc[IDX+1:2];
    assign if_tag         = if_pc[XLEN-1:IDX+2];
    assign upd_idx        = upd_pc[IDX+1:2];
    assign upd_tag        = upd_pc[XLEN-1:IDX+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not bypassed
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        pred_taken  = if_hit && ctr_q[if_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
    end

    // Table training: saturating counters on hit, allocate weakly-taken on a taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WEAK;
            end
        end
    end

    // Saturating statistics counters
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid && stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
        if (upd_valid && upd_mispredict && stat_mp_q != '1) stat_mp_d = stat_mp_q + 32'd1;
    end

    // Table and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

`ifdef BPU_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Circular stack: pointer marks the top; a push when full overwrites the oldest slot
    always_comb begin
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ptr_inc = PTR_W'((32'(ptr_q) + 32'd1) % RAS_DEPTH);
        ptr_dec = PTR_W'((32'(ptr_q) + RAS_DEPTH - 32'd1) % RAS_DEPTH);
        if (ras_push && ras_pop && cnt_q != '0) begin
            ras_d[ptr_q] = ras_push_addr;
        end else if (ras_push) begin
            ptr_d        = ptr_inc;
            ras_d[ptr_inc] = ras_push_addr;
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
        end else if (ras_pop && cnt_q != '0) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - 1'b1;
        end
        ras_top   = (cnt_q != '0) ? ras_q[ptr_q] : '0;
        ras_empty = (cnt_q == '0);
    end

    // RAS registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end
`else
    logic unused_ras;

    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

endmodule
